onehot_bus_arbiter: RTL

//   Round-robin arbiter and sequencer for the shared 32-bit Multiplexer8to1 bus.

---
 rtl/onehot_bus_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/onehot_bus_arbiter.sv
// Round-robin arbiter for an 8-way one-hot bus mux with bounded tenure.
// Registers the mux output with a valid flag one cycle behind the select.
module onehot_bus_arbiter #(
   parameter int unsigned bus_size = 32,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          req,
   input  logic [bus_size-1:0] bus_in,
   output logic [7:0]          sel,
   output logic [2:0]          gnt_id,
   output logic [bus_size-1:0] bus_out,
   output logic                bus_valid
);

   localparam int unsigned HW = $clog2(MAX_HOLD + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          sel_q, sel_d;
   logic [2:0]          gnt_id_q, gnt_id_d;
   logic [2:0]          ptr_q, ptr_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic [bus_size-1:0] bus_out_q;
   logic                bus_valid_q;

   logic [2:0]          pick_base;
   logic [3:0]          pick_res;
   logic                release_c;

   // Returns {found, index} of the first set request scanning from base upward.
   function automatic logic [3:0] pick_f(input logic [7:0] r, input logic [2:0] base);
      logic [3:0] res;
      logic [2:0] idx;
      res = '0;
      for (int k = 7; k >= 0; k--) begin
         idx = base + 3'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         gnt_id_q <= '0;
         ptr_q    <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         gnt_id_q <= gnt_id_d;
         ptr_q    <= ptr_d;
         hold_q   <= hold_d;
      end
   end

   // Next-state: on release, re-pick starting just past the owner so it is scanned last.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      gnt_id_d  = gnt_id_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      release_c = 1'b0;
      pick_base = (state_q == GRANT) ? (gnt_id_q + 3'd1) : ptr_q;
      pick_res  = pick_f(req, pick_base);

      case (state_q)
         IDLE: begin
            if (pick_res[3]) begin
               state_d  = GRANT;
               sel_d    = 8'(1) << pick_res[2:0];
               gnt_id_d = pick_res[2:0];
               hold_d   = HW'(1);
            end
         end
         GRANT: begin
            release_c = !req[gnt_id_q] || (hold_q == HW'(MAX_HOLD));
            if (release_c) begin
               ptr_d = gnt_id_q + 3'd1;
               if (pick_res[3]) begin
                  sel_d    = 8'(1) << pick_res[2:0];
                  gnt_id_d = pick_res[2:0];
                  hold_d   = HW'(1);
               end else begin
                  state_d = IDLE;
                  sel_d   = '0;
                  hold_d  = '0;
               end
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
            hold_d  = '0;
         end
      endcase
   end

   // Capture the mux output while a select is active; valid tracks the select one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_out_q   <= '0;
         bus_valid_q <= 1'b0;
      end else begin
         bus_valid_q <= (sel_q != 8'd0);
         if (sel_q != 8'd0) bus_out_q <= bus_in;
      end
   end

   assign sel       = sel_q;
   assign gnt_id    = gnt_id_q;
   assign bus_out   = bus_out_q;
   assign bus_valid = bus_valid_q;

endmodule
